// File: rtl/dmux4way16_buffer_pkg.sv
// Shared definitions for the 4-way 16-bit demux buffer: data width,
// channel indices, select encoding, the per-slot state type and the
// round-robin pointer step.
package dmux4way16_buffer_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic [1:0] ch_idx_t;

    // Channel indices; these also serve as the sel / ptr encoding.
    localparam ch_idx_t CH_A = 2'd0;
    localparam ch_idx_t CH_B = 2'd1;
    localparam ch_idx_t CH_C = 2'd2;
    localparam ch_idx_t CH_D = 2'd3;

    localparam ch_idx_t SEL_A = 2'b00;
    localparam ch_idx_t SEL_B = 2'b01;
    localparam ch_idx_t SEL_C = 2'b10;
    localparam ch_idx_t SEL_D = 2'b11;

    localparam logic [3:0] ALL_FULL = 4'b1111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Round-robin step; 2'b11 naturally wraps to 2'b00.
    function automatic ch_idx_t ptr_inc(input ch_idx_t p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/dmux4way16_buffer_slot.sv
// One output channel: a data register plus an EMPTY/FULL flag.
// A load always wins over an ack arriving in the same cycle.
module dmux4way16_buffer_slot
    import dmux4way16_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             ack_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // State and data registers; reset empties the slot and zeroes the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next-state: fill on load, drain on ack only when no load is present.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else if (ack_i) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    // Data next-value: only a load changes it; an ack leaves the last word visible.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = din_i;
        end else begin
            data_d = data_q;
        end
    end

    // Outputs come straight from registered state.
    always_comb begin
        valid_o = (state_q == SLOT_FULL);
        dout_o  = data_q;
    end

endmodule

// File: rtl/dmux4way16_buffer.sv
// Receiving end of the 4-way 16-bit mux path: steers one word stream into
// four held channels a/b/c/d, chosen by sel or by a round-robin pointer,
// and backpressures the source while the target channel is still full.
module dmux4way16_buffer
    import dmux4way16_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             auto_mode,
    input  logic [3:0]       ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       out_valid,
    output logic [1:0]       ptr,
    output logic             frame_done
);

    ch_idx_t          tgt_s;
    logic             accept_s;
    logic [3:0]       load_s;
    logic [3:0]       valid_s;
    logic [3:0]       valid_nxt_s;
    logic [WIDTH-1:0] data_s [4];

    ch_idx_t          ptr_q;
    ch_idx_t          ptr_d;
    logic             frame_q;
    logic             frame_d;

    // Target selection, handshake and per-channel load strobes.
    always_comb begin
        tgt_s    = auto_mode ? ptr_q : sel;
        in_ready = ~valid_s[tgt_s] | ack[tgt_s];
        accept_s = in_valid & in_ready;
        load_s   = 4'b0000;
        if (accept_s) begin
            load_s[tgt_s] = 1'b1;
        end else begin
            load_s = 4'b0000;
        end
    end

    // Pointer advances only on accepts taken in auto mode.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s && auto_mode) begin
            ptr_d = ptr_inc(ptr_q);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Frame completion: this accept makes all four channels full where they were not before.
    always_comb begin
        valid_nxt_s = (valid_s & ~ack) | load_s;
        frame_d     = 1'b0;
        if (accept_s && (valid_nxt_s == ALL_FULL) && (valid_s != ALL_FULL)) begin
            frame_d = 1'b1;
        end else begin
            frame_d = 1'b0;
        end
    end

    // Pointer and frame pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= CH_A;
            frame_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        dmux4way16_buffer_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load_s[i]),
            .ack_i   (ack[i]),
            .din_i   (in),
            .dout_o  (data_s[i]),
            .valid_o (valid_s[i])
        );
    end

    // Output mapping onto the named channel ports.
    always_comb begin
        a          = data_s[CH_A];
        b          = data_s[CH_B];
        c          = data_s[CH_C];
        d          = data_s[CH_D];
        out_valid  = valid_s;
        ptr        = ptr_q;
        frame_done = frame_q;
    end

endmodule
